// File: rtl/pattern_sequencer.sv
// pattern_sequencer: chooses the active test pattern for the pixel generator.
// Key requests and auto-cycling are held back until the end of the active
// frame, so a pattern change never lands in the middle of a frame.
module pattern_sequencer #(
  parameter logic [10:0] H_DISP      = 11'd1280,
  parameter logic [10:0] V_DISP      = 11'd720,
  parameter int          NUM_PAT     = 5,
  parameter logic [15:0] AUTO_FRAMES = 16'd120
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        key_next,
  input  logic        key_prev,
  input  logic        auto_en,
  output logic [2:0]  pattern_sel,
  output logic        pattern_upd,
  output logic        req_pending,
  output logic [15:0] frame_cnt
);

  localparam logic [2:0]  LAST_PAT  = 3'(NUM_PAT - 1);
  localparam logic [15:0] AUTO_LAST = AUTO_FRAMES - 16'd1;
  localparam logic [10:0] X_LAST    = H_DISP - 11'd1;
  localparam logic [10:0] Y_LAST    = V_DISP - 11'd1;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic        upd_q, upd_d;
  logic        pend_q, pend_d;
  logic        dir_q, dir_d;
  logic [15:0] cnt_q, cnt_d;
  logic        eof_hit_r_q, eof_hit_r_d;
  logic        eof_d_q, eof_d_d;

  logic        eof_hit;
  logic        eof_p;
  logic        key_valid;
  logic        step_up;
  logic        commit;
  logic [2:0]  sel_step;

  // End-of-frame strobe: one pulse per arrival on the last active pixel,
  // even if the coordinates dwell there for several cycles.
  always_comb begin
    eof_hit     = (pixel_xpos == X_LAST) && (pixel_ypos == Y_LAST);
    eof_hit_r_d = eof_hit;
    eof_d_d     = eof_hit_r_q;
    eof_p       = eof_hit_r_q & ~eof_d_q;
  end

  // Neighbouring pattern index in the commit direction, wrapping at both ends.
  always_comb begin
    key_valid = key_next ^ key_prev;
    step_up   = pend_q ? dir_q : 1'b1;
    if (step_up) begin
      sel_step = (sel_q == LAST_PAT) ? 3'd0 : sel_q + 3'd1;
    end else begin
      sel_step = (sel_q == 3'd0) ? LAST_PAT : sel_q - 3'd1;
    end
  end

  // Next-state logic: the commit edge loads the new pattern so that the
  // registered outputs carry it for the whole S_LOAD cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    upd_d   = 1'b0;
    pend_d  = pend_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;

    case (state_q)
      S_RUN: begin
        if (eof_p) begin
          if (pend_q || (auto_en && (cnt_q == AUTO_LAST))) begin
            commit  = 1'b1;
            state_d = S_LOAD;
            sel_d   = sel_step;
            upd_d   = 1'b1;
            cnt_d   = 16'd0;
          end else if (auto_en) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          end else begin
            cnt_d = 16'd0;
          end
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    // A fresh key wins over the clear, so a key landing on the commit
    // cycle survives to the next end of frame.
    if (commit) begin
      pend_d = 1'b0;
    end
    if (key_valid) begin
      pend_d = 1'b1;
      dir_d  = key_next;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q     <= S_RUN;
      sel_q       <= 3'd0;
      upd_q       <= 1'b0;
      pend_q      <= 1'b0;
      dir_q       <= 1'b0;
      cnt_q       <= 16'd0;
      eof_hit_r_q <= 1'b0;
      eof_d_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      upd_q       <= upd_d;
      pend_q      <= pend_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      eof_hit_r_q <= eof_hit_r_d;
      eof_d_q     <= eof_d_d;
    end
  end

  assign pattern_sel = sel_q;
  assign pattern_upd = upd_q;
  assign req_pending = pend_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Testbench for pattern_sequencer: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// behavioural model of the sequencing rules.
module tb_pattern_sequencer;

  localparam int NP = 5;
  localparam int AF = 3;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [10:0] px, py;
  logic        kn, kp, ae;
  logic [2:0]  pattern_sel;
  logic        pattern_upd;
  logic        req_pending;
  logic [15:0] frame_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model of the outputs
  int m_sel, m_cnt;
  bit m_upd, m_pend, m_dir, m_loading;
  bit m_match_1ago, m_match_2ago;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .H_DISP(11'd1280),
    .V_DISP(11'd720),
    .NUM_PAT(NP),
    .AUTO_FRAMES(16'(AF))
  ) dut (
    .pixel_clk(clk),
    .sys_rst(sys_rst),
    .pixel_xpos(px),
    .pixel_ypos(py),
    .key_next(kn),
    .key_prev(kp),
    .auto_en(ae),
    .pattern_sel(pattern_sel),
    .pattern_upd(pattern_upd),
    .req_pending(req_pending),
    .frame_cnt(frame_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare, then advance the model with the inputs the next edge will see.
  initial begin
    bit eofp, do_commit, up;
    m_sel = 0; m_cnt = 0; m_upd = 0; m_pend = 0; m_dir = 0; m_loading = 0;
    m_match_1ago = 0; m_match_2ago = 0;
    forever begin
      @(negedge clk);
      chk("model_sel", int'(pattern_sel), m_sel);
      chk("model_upd", int'(pattern_upd), int'(m_upd));
      chk("model_pend", int'(req_pending), int'(m_pend));
      chk("model_cnt", int'(frame_cnt), m_cnt);
      if (sys_rst) begin
        m_sel = 0; m_cnt = 0; m_upd = 0; m_pend = 0; m_dir = 0; m_loading = 0;
        m_match_1ago = 0; m_match_2ago = 0;
      end else begin
        eofp      = m_match_1ago && !m_match_2ago;
        do_commit = !m_loading && eofp && (m_pend || (ae && m_cnt == AF - 1));
        if (m_loading) begin
          m_upd = 0;
          m_loading = 0;
        end else if (do_commit) begin
          up = m_pend ? m_dir : 1'b1;
          m_sel = up ? (m_sel + 1) % NP : (m_sel + NP - 1) % NP;
          m_upd = 1;
          m_cnt = 0;
          m_loading = 1;
        end else begin
          m_upd = 0;
          if (eofp) m_cnt = ae ? ((m_cnt < 65535) ? m_cnt + 1 : 65535) : 0;
        end
        if (kn != kp) begin
          m_pend = 1;
          m_dir = kn;
        end else if (do_commit) begin
          m_pend = 0;
        end
        m_match_2ago = m_match_1ago;
        m_match_1ago = (px == 11'd1279) && (py == 11'd719);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    kn = 0; kp = 0; px = 11'd0; py = 11'd0;
  endtask

  task automatic do_reset();
    sys_rst = 1; idle(); tick(); sys_rst = 0;
  endtask

  // One match cycle, then wait until any commit has settled.
  task automatic eof_frame();
    px = 11'd1279; py = 11'd719; tick();
    px = 11'd0; py = 11'd0; tick(); tick();
  endtask

  task automatic key(input logic n, input logic p);
    kn = n; kp = p; tick();
    kn = 0; kp = 0; tick();
  endtask

  initial begin
    int hold;
    sys_rst = 1; ae = 0; idle();

    // Reset held for three cycles
    tick(); tick(); tick();
    chk("rst_sel", int'(pattern_sel), 0);
    chk("rst_upd", int'(pattern_upd), 0);
    chk("rst_pend", int'(req_pending), 0);
    chk("rst_cnt", int'(frame_cnt), 0);
    sys_rst = 0; tick();

    // Key mid-frame, committed two cycles after the coordinate match
    kn = 1; px = 11'd100; py = 11'd5; tick();
    kn = 0; tick();
    chk("t2_pend", int'(req_pending), 1);
    px = 11'd1279; py = 11'd719; tick();
    px = 11'd0; py = 11'd0;
    chk("t2_sel_n1", int'(pattern_sel), 0);
    chk("t2_pend_n1", int'(req_pending), 1);
    tick();
    chk("t2_sel_n2", int'(pattern_sel), 1);
    chk("t2_upd_n2", int'(pattern_upd), 1);
    chk("t2_pend_n2", int'(req_pending), 0);
    tick();
    chk("t2_upd_n3", int'(pattern_upd), 0);

    // Wrap on prev, then a full lap forward
    do_reset();
    key(0, 1); eof_frame();
    chk("t3_wrap_prev", int'(pattern_sel), 4);
    key(1, 0); eof_frame();
    chk("t3_wrap_next", int'(pattern_sel), 0);
    for (int i = 0; i < 4; i++) begin
      key(1, 0); eof_frame();
    end
    chk("t3_lap", int'(pattern_sel), 4);

    // Auto-cycling every AF frames
    do_reset();
    ae = 1;
    for (int i = 1; i <= 9; i++) begin
      eof_frame();
      chk("t4_cnt", int'(frame_cnt), i % 3);
      chk("t4_sel", int'(pattern_sel), i / 3);
    end
    ae = 0; eof_frame(); eof_frame();
    chk("t4_off_cnt", int'(frame_cnt), 0);
    chk("t4_off_sel", int'(pattern_sel), 3);

    // Simultaneous keys ignored; last key before EOF wins
    do_reset();
    key(1, 1);
    chk("t5_both_pend", int'(req_pending), 0);
    eof_frame();
    chk("t5_both_sel", int'(pattern_sel), 0);
    key(1, 0); key(1, 0); key(1, 0); key(0, 1);
    eof_frame();
    chk("t5_last_wins", int'(pattern_sel), 4);
    key(1, 0);
    px = 11'd1279; py = 11'd719;
    tick(); tick(); tick(); tick();
    idle(); tick(); tick();
    chk("t5_held_eof", int'(pattern_sel), 0);

    // Reset discards a pending key
    key(1, 0); key(1, 0);
    do_reset();
    chk("t6_rst_pend", int'(req_pending), 0);
    eof_frame();
    chk("t6_rst_sel", int'(pattern_sel), 0);

    // Key on the eof_p cycle waits for the following EOF
    px = 11'd1279; py = 11'd719; tick();
    kn = 1; px = 11'd0; py = 11'd0; tick();
    kn = 0;
    chk("t6_coinc_sel", int'(pattern_sel), 0);
    chk("t6_coinc_pend", int'(req_pending), 1);
    tick(); eof_frame();
    chk("t6_next_eof", int'(pattern_sel), 1);
    key(0, 1);
    px = 11'd1279; py = 11'd719; tick();
    kn = 1; px = 11'd0; py = 11'd0; tick();
    kn = 0;
    chk("t6_prev_commit", int'(pattern_sel), 0);
    chk("t6_keep_pend", int'(req_pending), 1);
    tick(); eof_frame();
    chk("t6_next_commit", int'(pattern_sel), 1);

    // Randomized run
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      sys_rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0) ae = ~ae;
      kn = ($urandom_range(0, 19) == 0);
      kp = ($urandom_range(0, 19) == 0);
      if (hold > 0) begin
        hold--;
      end else if ($urandom_range(0, 29) == 0) begin
        px = 11'd1279; py = 11'd719;
        hold = $urandom_range(0, 2);
      end else if ($urandom_range(0, 9) == 0) begin
        px = 11'd1279; py = 11'd718;
      end else begin
        px = 11'($urandom_range(0, 1279));
        py = 11'($urandom_range(0, 719));
      end
      tick();
    end
    sys_rst = 0; idle(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
